// File: rtl/amp_ramp_pkg.sv
// Shared defaults and types for the ramped multi-channel amplitude register.
package amp_ramp_pkg;

    // Default configuration of amp_ramp_reg
    localparam int unsigned WIDTH_DEF    = 9;
    localparam int unsigned CHANNELS_DEF = 2;
    localparam int unsigned STEP_DEF     = 4;
    localparam int unsigned TICK_DIV_DEF = 16;

    // Amplitude word at the default width
    typedef logic [WIDTH_DEF-1:0] amp_t;

    // Direction of a channel's ramp, derived from comparing amp with its effective target
    typedef enum logic [1:0] {
        SETTLED,
        UP,
        DOWN
    } ramp_dir_e;

endpackage

// File: rtl/amp_ramp_chan.sv
// One channel of the ramped amplitude register: target register, slew-limited stepper and
// ramping flag. Mute support is compiled in with AMP_RAMP_MUTE_EN.
module amp_ramp_chan
    import amp_ramp_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned STEP  = STEP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
`ifdef AMP_RAMP_MUTE_EN
    input  logic             mute,
`endif
    output logic [WIDTH-1:0] amp,
    output logic             ramping
);

    localparam logic [WIDTH:0] StepW = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0]        target_q;
    logic [WIDTH-1:0]        amp_q;
    logic [WIDTH-1:0]        amp_d;
    logic [WIDTH-1:0]        eff_target;
    logic signed [WIDTH:0]   diff;
    logic [WIDTH:0]          mag;
    logic [WIDTH-1:0]        step;
    ramp_dir_e               dir;

    // Effective target: muting forces a ramp to zero while keeping the stored target
    always_comb begin
`ifdef AMP_RAMP_MUTE_EN
        eff_target = mute ? '0 : target_q;
`else
        eff_target = target_q;
`endif
    end

    // Direction and clamped step size; one extra bit keeps the difference from wrapping
    always_comb begin
        diff = $signed({1'b0, eff_target}) - $signed({1'b0, amp_q});
        if (diff > 0) begin
            dir = UP;
        end else if (diff < 0) begin
            dir = DOWN;
        end else begin
            dir = SETTLED;
        end
        mag  = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
        // step never exceeds the distance to target, so amp cannot overshoot or wrap
        step = (mag > StepW) ? StepW[WIDTH-1:0] : mag[WIDTH-1:0];
    end

    // Next amplitude: move by one clamped step on a tick, otherwise hold
    always_comb begin
        amp_d = amp_q;
        if (tick) begin
            case (dir)
                UP:      amp_d = amp_q + step;
                DOWN:    amp_d = amp_q - step;
                default: amp_d = amp_q;
            endcase
        end
    end

    // Target and amplitude registers; a same-edge write does not affect this edge's step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_q <= '0;
            amp_q    <= '0;
        end else begin
            if (wr_en) begin
                target_q <= wr_data;
            end
            amp_q <= amp_d;
        end
    end

    // Outputs derive only from registered state
    always_comb begin
        amp     = amp_q;
        ramping = (dir != SETTLED);
    end

endmodule

// File: rtl/amp_ramp_reg.sv
// Multi-channel amplitude register with slew-limited updates. Owns the shared ramp tick
// counter and the write-address decode; each channel is an amp_ramp_chan instance.
// Optional feature macro: AMP_RAMP_MUTE_EN adds a mute input that ramps all channels to zero.
module amp_ramp_reg
    import amp_ramp_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DEF,
    parameter int unsigned CHANNELS = CHANNELS_DEF,
    parameter int unsigned STEP     = STEP_DEF,
    parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [$clog2(CHANNELS)-1:0] ch_sel,
    input  logic [WIDTH-1:0]            new_amp,
`ifdef AMP_RAMP_MUTE_EN
    input  logic                        mute,
`endif
    output logic [CHANNELS*WIDTH-1:0]   amp,
    output logic [CHANNELS-1:0]         ramping
);

    localparam int unsigned CntW = $clog2(TICK_DIV);

    // Elaboration-time parameter sanity
    if (CHANNELS < 2) begin : g_bad_channels
        $error("amp_ramp_reg: CHANNELS must be at least 2");
    end
    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("amp_ramp_reg: TICK_DIV must be at least 2");
    end
    if (STEP < 1 || STEP > (2 ** WIDTH) - 1) begin : g_bad_step
        $error("amp_ramp_reg: STEP out of range");
    end

    logic [CntW-1:0]     tick_cnt_q;
    logic [CntW-1:0]     tick_cnt_d;
    logic                tick;
    logic [CHANNELS-1:0] wr_en;

    // Free-running tick divider shared by all channels
    always_comb begin
        tick       = (tick_cnt_q == CntW'(TICK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    // Tick counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Write-address decode; an out-of-range ch_sel matches no channel and is dropped
    always_comb begin
        wr_en = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (en && (32'(ch_sel) == c)) begin
                wr_en[c] = 1'b1;
            end
        end
    end

`ifdef AMP_RAMP_MUTE_EN
    logic mute_q;

    // Registered mute keeps ramping free of any input-to-output path
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mute_q <= 1'b0;
        end else begin
            mute_q <= mute;
        end
    end
`endif

    // Channel array: element c drives amp[c*WIDTH +: WIDTH] and ramping[c]
    amp_ramp_chan #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) i_chan [CHANNELS-1:0] (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .wr_en   (wr_en),
        .wr_data (new_amp),
`ifdef AMP_RAMP_MUTE_EN
        .mute    (mute_q),
`endif
        .amp     (amp),
        .ramping (ramping)
    );

endmodule

// File: tb/tb_amp_ramp_reg.sv
// Self-checking bench for amp_ramp_reg: a cycle model pushes expected outputs to a queue before
// each edge, which are popped and compared after it; directed checks pin the key ramp values.
module tb_amp_ramp_reg;

    localparam int unsigned WIDTH    = 9;
    localparam int unsigned CHANNELS = 3;
    localparam int unsigned STEP     = 4;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned BIG_STEP = 511;

    typedef struct packed {
        logic [CHANNELS*WIDTH-1:0] amp;
        logic [CHANNELS-1:0]       ramp;
    } exp_t;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        en;
    logic [1:0]                  ch_sel;
    logic [WIDTH-1:0]            new_amp;
    logic                        mute;
    logic [CHANNELS*WIDTH-1:0]   amp;
    logic [CHANNELS-1:0]         ramping;

    logic                        en_b;
    logic [1:0]                  ch_sel_b;
    logic [WIDTH-1:0]            new_amp_b;
    logic                        mute_b;
    logic [CHANNELS*WIDTH-1:0]   amp_b;
    logic [CHANNELS-1:0]         ramping_b;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];

    // Reference model state
    int m_amp [CHANNELS];
    int m_tgt [CHANNELS];
    int m_cnt;
    bit m_mute;

    always #5 clk = ~clk;

    amp_ramp_reg #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .STEP     (STEP),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .ch_sel  (ch_sel),
        .new_amp (new_amp),
`ifdef AMP_RAMP_MUTE_EN
        .mute    (mute),
`endif
        .amp     (amp),
        .ramping (ramping)
    );

    amp_ramp_reg #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .STEP     (BIG_STEP),
        .TICK_DIV (TICK_DIV)
    ) dut_big (
        .clk     (clk),
        .rst     (rst),
        .en      (en_b),
        .ch_sel  (ch_sel_b),
        .new_amp (new_amp_b),
`ifdef AMP_RAMP_MUTE_EN
        .mute    (mute_b),
`endif
        .amp     (amp_b),
        .ramping (ramping_b)
    );

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned amp_of(input int c);
        return 32'(amp[c*WIDTH +: WIDTH]);
    endfunction

    function automatic int unsigned amp_b_of(input int c);
        return 32'(amp_b[c*WIDTH +: WIDTH]);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CHANNELS; c++) begin
            m_amp[c] = 0;
            m_tgt[c] = 0;
        end
        m_cnt  = 0;
        m_mute = 1'b0;
    endtask

    // One clock: advance the model, queue its prediction, clock the DUT, compare
    task automatic cyc(output bit was_tick);
        exp_t e;
        bit   t;
        int   eff;
        t = (m_cnt == TICK_DIV - 1);
        if (rst) begin
            model_reset();
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                eff = m_mute ? 0 : m_tgt[c];
                if (t) begin
                    if (m_amp[c] < eff) begin
                        m_amp[c] = (m_amp[c] + STEP > eff) ? eff : m_amp[c] + STEP;
                    end else if (m_amp[c] > eff) begin
                        m_amp[c] = (m_amp[c] - eff > STEP) ? m_amp[c] - STEP : eff;
                    end
                end
            end
            if (en && int'(ch_sel) < CHANNELS) begin
                m_tgt[ch_sel] = int'(new_amp);
            end
            m_mute = mute;
            m_cnt  = t ? 0 : m_cnt + 1;
        end
        for (int c = 0; c < CHANNELS; c++) begin
            eff = m_mute ? 0 : m_tgt[c];
            e.amp[c*WIDTH +: WIDTH] = WIDTH'(m_amp[c]);
            e.ramp[c]               = (m_amp[c] != eff);
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("amp", 32'(amp), 32'(e.amp));
        check_eq("ramping", 32'(ramping), 32'(e.ramp));
        was_tick = t && !rst;
    endtask

    task automatic wait_tick();
        bit t = 1'b0;
        for (int i = 0; i < 2 * TICK_DIV && !t; i++) begin
            cyc(t);
        end
        if (!t) check_eq("tick_timeout", 0, 1);
    endtask

    // Stop just before a tick edge, so the next cyc() lands on the tick
    task automatic run_to_pre_tick();
        bit t;
        for (int i = 0; i < TICK_DIV && m_cnt != TICK_DIV - 1; i++) begin
            cyc(t);
        end
    endtask

    task automatic write(input int ch, input int val);
        bit t;
        en      = 1'b1;
        ch_sel  = 2'(ch);
        new_amp = WIDTH'(val);
        cyc(t);
        en      = 1'b0;
    endtask

    task automatic write_big(input int ch, input int val);
        bit t;
        en_b      = 1'b1;
        ch_sel_b  = 2'(ch);
        new_amp_b = WIDTH'(val);
        cyc(t);
        en_b      = 1'b0;
    endtask

    initial begin
        bit t;
        rst       = 1'b1;
        en        = 1'b0;
        ch_sel    = '0;
        new_amp   = '0;
        mute      = 1'b0;
        en_b      = 1'b0;
        ch_sel_b  = '0;
        new_amp_b = '0;
        mute_b    = 1'b0;
        model_reset();

        // 1. Reset and idle
        for (int i = 0; i < 3; i++) cyc(t);
        check_eq("rst_amp", 32'(amp), 0);
        check_eq("rst_ramping", 32'(ramping), 0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) cyc(t);
        check_eq("idle_amp", 32'(amp), 0);

        // 2. Up ramp on ch0
        write(0, 10);
        wait_tick();
        check_eq("up_4", amp_of(0), 4);
        check_eq("up_ramping", 32'(ramping[0]), 1);
        wait_tick();
        check_eq("up_8", amp_of(0), 8);
        wait_tick();
        check_eq("up_10", amp_of(0), 10);
        check_eq("up_settled", 32'(ramping[0]), 0);
        check_eq("up_ch1", amp_of(1), 0);
        check_eq("up_ch2", amp_of(2), 0);

        // 3a. Down ramp
        write(0, 2);
        wait_tick();
        check_eq("down_6", amp_of(0), 6);
        wait_tick();
        check_eq("down_2", amp_of(0), 2);

        // 3b. Retarget mid-ramp, clamped at the new target
        write(1, 511);
        wait_tick();
        check_eq("ret_4", amp_of(1), 4);
        wait_tick();
        check_eq("ret_8", amp_of(1), 8);
        write(1, 5);
        wait_tick();
        check_eq("ret_5", amp_of(1), 5);
        check_eq("ret_settled", 32'(ramping[1]), 0);

        // 3c. Write on the same edge as a tick
        run_to_pre_tick();
        write(2, 20);
        check_eq("same_edge_hold", amp_of(2), 0);
        wait_tick();
        check_eq("same_edge_4", amp_of(2), 4);
        for (int i = 0; i < 4; i++) wait_tick();
        check_eq("ch2_20", amp_of(2), 20);

        // 4a. Out-of-range channel select is dropped
        write(3, 100);
        wait_tick();
        wait_tick();
        check_eq("oob_ch0", amp_of(0), 2);
        check_eq("oob_ch1", amp_of(1), 5);
        check_eq("oob_ch2", amp_of(2), 20);

        // 4b. Full-scale step, no wrap
        write_big(0, 511);
        wait_tick();
        check_eq("big_511", amp_b_of(0), 511);
        check_eq("big_settled", 32'(ramping_b), 0);
        write_big(0, 0);
        wait_tick();
        check_eq("big_0", amp_b_of(0), 0);
        check_eq("big_ch1", amp_b_of(1), 0);

        // 5. Asynchronous reset mid-ramp
        write(0, 200);
        wait_tick();
        wait_tick();
        check_eq("pre_rst_10", amp_of(0), 10);
        #3;
        rst = 1'b1;
        #1;
        check_eq("async_rst_amp", 32'(amp), 0);
        check_eq("async_rst_ramping", 32'(ramping), 0);
        model_reset();
        cyc(t);
        cyc(t);
        rst = 1'b0;
        wait_tick();
        wait_tick();
        check_eq("post_rst_amp0", amp_of(0), 0);

`ifdef AMP_RAMP_MUTE_EN
        // 6. Mute ramps down, targets stay writable, unmute ramps back
        write(0, 12);
        for (int i = 0; i < 3; i++) wait_tick();
        check_eq("mute_pre_12", amp_of(0), 12);
        mute = 1'b1;
        wait_tick();
        check_eq("mute_8", amp_of(0), 8);
        write(1, 7);
        wait_tick();
        check_eq("mute_4", amp_of(0), 4);
        wait_tick();
        check_eq("mute_0", amp_of(0), 0);
        check_eq("mute_ch1", amp_of(1), 0);
        mute = 1'b0;
        wait_tick();
        check_eq("unmute_4", amp_of(0), 4);
        wait_tick();
        check_eq("unmute_8", amp_of(0), 8);
        wait_tick();
        check_eq("unmute_12", amp_of(0), 12);
        check_eq("unmute_ch1", amp_of(1), 7);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
